// File: rtl/si5340_cfg_ctrl.sv
// si5340_cfg_ctrl
//   Walks a configuration ROM and writes every entry to an Si5340 over a
//   byte-level I2C master.  Each entry is {page, register, data}.  A page
//   select write (reg 0x01) is issued before the register write.  After the
//   preamble entries the controller waits a fixed number of clocks so that
//   the device can finish its internal calibration.
//
//   Optional feature macro: CFG_PAGE_CACHE_EN
//     When defined, the page select write is skipped if the entry's page
//     matches the last page written during this load.
//
// Ports
//   clk_i            system clock
//   arstn_i          asynchronous active-low reset
//   start_i          one-cycle load request (honoured in IDLE/DONE/ERR only)
//   busy_o           load in progress
//   done_o           last load completed without NACK
//   err_o            last load aborted on NACK
//   rom_addr_o       ROM entry index
//   rom_data_i       ROM entry, valid one cycle after rom_addr_o
//   i2c_valid_o      byte command valid
//   i2c_ready_i      byte master accepts the command
//   i2c_data_o       byte to send
//   i2c_start_o      issue START before this byte
//   i2c_stop_o       issue STOP after this byte
//   i2c_ack_valid_i  one-cycle pulse: byte finished on the bus
//   i2c_nack_i       NACK flag, qualified by i2c_ack_valid_i
//
// States
//   IDLE     | waiting for start_i after reset
//   FETCH    | rom_addr_o presented to the ROM
//   LATCH    | ROM word captured into the entry register
//   PAGE_TX  | offering a byte of the page select write
//   REG_TX   | offering a byte of the register write
//   WAIT_ACK | byte accepted, waiting for its bus completion
//   PAUSE    | post-preamble wait, no bus activity
//   NEXT     | advance to the next ROM entry
//   DONE     | load finished cleanly
//   ERR      | load aborted on NACK

module si5340_cfg_ctrl #(
    parameter int         MEM_DEPTH    = 326,
    parameter int         MEM_WIDTH    = 24,
    parameter int         DATA_WIDTH   = 8,
    parameter logic [6:0] SLAVE_ADDR   = 7'h74,
    parameter int         PREAMBLE_LEN = 3,
    parameter int         PAUSE_CYCLES = 37_500_000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
    input  logic [MEM_WIDTH-1:0]         rom_data_i,
    output logic                         i2c_valid_o,
    input  logic                         i2c_ready_i,
    output logic [DATA_WIDTH-1:0]        i2c_data_o,
    output logic                         i2c_start_o,
    output logic                         i2c_stop_o,
    input  logic                         i2c_ack_valid_i,
    input  logic                         i2c_nack_i
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(PAUSE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, PAGE_TX, REG_TX, WAIT_ACK, PAUSE, NEXT, DONE, ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   entry_q, entry_d;
    logic [1:0]             bcnt_q, bcnt_d;
    logic                   page_ph_q, page_ph_d;   // 1: sending page select
    logic [PW-1:0]          pause_q, pause_d;
    logic                   skip_page;
    logic [DATA_WIDTH-1:0]  tx_byte;

    wire [DATA_WIDTH-1:0] page_f = entry_q[MEM_WIDTH-1 -: DATA_WIDTH];
    wire [DATA_WIDTH-1:0] reg_f  = entry_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
    wire [DATA_WIDTH-1:0] dat_f  = entry_q[DATA_WIDTH-1:0];
    wire                  last_entry = (addr_q == AW'(MEM_DEPTH - 1));

`ifdef CFG_PAGE_CACHE_EN
    logic [DATA_WIDTH-1:0] cache_q;
    logic                  cache_vld_q;

    wire start_ok = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    // Cache is only trusted once the page write has actually been ACKed.
    wire page_acked = (state_q == WAIT_ACK) && i2c_ack_valid_i && !i2c_nack_i &&
                      (bcnt_q == 2'd2) && page_ph_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
        end else if (start_ok) begin
            cache_vld_q <= 1'b0;
        end else if (page_acked) begin
            cache_q     <= page_f;
            cache_vld_q <= 1'b1;
        end
    end

    // Decided in LATCH, so compare against the ROM word being captured.
    assign skip_page = cache_vld_q && (rom_data_i[MEM_WIDTH-1 -: DATA_WIDTH] == cache_q);
`else
    assign skip_page = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            entry_q   <= '0;
            bcnt_q    <= '0;
            page_ph_q <= 1'b0;
            pause_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            entry_q   <= entry_d;
            bcnt_q    <= bcnt_d;
            page_ph_q <= page_ph_d;
            pause_q   <= pause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        entry_d   = entry_q;
        bcnt_d    = bcnt_q;
        page_ph_d = page_ph_q;
        pause_d   = pause_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                entry_d = rom_data_i;
                bcnt_d  = 2'd0;
                if (skip_page) begin
                    page_ph_d = 1'b0;
                    state_d   = REG_TX;
                end else begin
                    page_ph_d = 1'b1;
                    state_d   = PAGE_TX;
                end
            end
            PAGE_TX, REG_TX: begin
                if (i2c_ready_i) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i2c_ack_valid_i) begin
                    if (i2c_nack_i) begin
                        state_d = ERR;
                    end else if (bcnt_q != 2'd2) begin
                        bcnt_d  = bcnt_q + 2'd1;
                        state_d = page_ph_q ? PAGE_TX : REG_TX;
                    end else if (page_ph_q) begin
                        page_ph_d = 1'b0;
                        bcnt_d    = 2'd0;
                        state_d   = REG_TX;
                    end else if (addr_q == AW'(PREAMBLE_LEN - 1)) begin
                        pause_d = PW'(PAUSE_CYCLES - 1);
                        state_d = PAUSE;
                    end else if (last_entry) begin
                        state_d = DONE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            PAUSE: begin
                if (pause_q == '0) state_d = last_entry ? DONE : NEXT;
                else               pause_d = pause_q - 1'b1;
            end
            NEXT: begin
                addr_d  = addr_q + 1'b1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte 0 is always the device write address; bytes 1/2 depend on phase.
    always_comb begin
        tx_byte = DATA_WIDTH'({SLAVE_ADDR, 1'b0});
        case (bcnt_q)
            2'd1:    tx_byte = page_ph_q ? DATA_WIDTH'(1) : reg_f;
            2'd2:    tx_byte = page_ph_q ? page_f : dat_f;
            default: tx_byte = DATA_WIDTH'({SLAVE_ADDR, 1'b0});
        endcase
    end

    assign i2c_valid_o = (state_q == PAGE_TX) || (state_q == REG_TX);
    assign i2c_data_o  = i2c_valid_o ? tx_byte : '0;
    assign i2c_start_o = i2c_valid_o && (bcnt_q == 2'd0);
    assign i2c_stop_o  = i2c_valid_o && (bcnt_q == 2'd2);
    assign busy_o      = !(state_q == IDLE || state_q == DONE || state_q == ERR);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign rom_addr_o  = addr_q;

endmodule

// File: tb/tb_si5340_cfg_ctrl.sv
module tb_si5340_cfg_ctrl;

    localparam int DEPTH = 4;
    localparam int PRE   = 1;
    localparam int PAUSE = 10;
`ifdef CFG_PAGE_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
    localparam int EXP_TXN  = 6;
`else
    localparam bit CACHE_ON = 1'b0;
    localparam int EXP_TXN  = 8;
`endif

    logic        clk, arstn, start, busy, done, err;
    logic [1:0]  rom_addr;
    logic [23:0] rom_data;
    logic        valid, ready, st, sp, ack_valid, nack;
    logic [7:0]  data;
    logic [23:0] rom [DEPTH];

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       p;
        int         gap;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0;
    int idle_cnt = 0, n_bytes = 0, n_txn = 0, flag_viol = 0;
    int bus_bytes = 0, nack_at = 0;

    si5340_cfg_ctrl #(
        .MEM_DEPTH(DEPTH), .MEM_WIDTH(24), .DATA_WIDTH(8), .SLAVE_ADDR(7'h74),
        .PREAMBLE_LEN(PRE), .PAUSE_CYCLES(PAUSE)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .start_i(start), .busy_o(busy),
        .done_o(done), .err_o(err), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .i2c_valid_o(valid), .i2c_ready_i(ready), .i2c_data_o(data),
        .i2c_start_o(st), .i2c_stop_o(sp), .i2c_ack_valid_i(ack_valid),
        .i2c_nack_i(nack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Bus model: every accepted byte completes on the bus three clocks later.
    initial begin
        ack_valid = 1'b0;
        nack      = 1'b0;
        forever begin
            @(negedge clk);
            if (arstn && valid && ready) begin
                bus_bytes++;
                @(posedge clk);
                repeat (2) @(posedge clk);
                #1;
                ack_valid = 1'b1;
                nack      = (bus_bytes == nack_at);
                @(posedge clk);
                #1;
                ack_valid = 1'b0;
                nack      = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (!arstn || ack_valid) idle_cnt = 0;
        else if (!valid)         idle_cnt++;
        if (!valid && (st || sp)) flag_viol++;
        if (valid && ready) begin
            n_bytes++;
            if (st) n_txn++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %0h want none", data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({data, st, sp} !== {e.d, e.s, e.p}) begin
                    bad++;
                    $display("FAIL byte: got d=%0h s=%0b p=%0b want d=%0h s=%0b p=%0b",
                             data, st, sp, e.d, e.s, e.p);
                end
                if (e.gap >= 0) begin
                    total++;
                    if (idle_cnt != e.gap) begin
                        bad++;
                        $display("FAIL gap: got %0d want %0d (byte %0h)", idle_cnt, e.gap, e.d);
                    end
                end
            end
        end
    end

    task automatic push_one(input logic [7:0] d, input logic s, input logic p,
                            input int g, inout int n, input int mx);
        if (n < mx) sb.push_back('{d: d, s: s, p: p, gap: g});
        n++;
    endtask

    // Expected byte stream of one load; gap is idle clocks before the byte
    // (-1: first byte after start, not checked).
    task automatic push_load(input int mx);
        int n = 0;
        logic [7:0] last_pg = 8'h00;
        bit have = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] pg;
            int g;
            bit need;
            pg   = rom[i][23:16];
            need = !(CACHE_ON && have && pg == last_pg);
            g    = (i == 0) ? -1 : ((i - 1 == PRE - 1) ? PAUSE + 3 : 3);
            if (need) begin
                push_one(8'hE8, 1'b1, 1'b0, g, n, mx);
                push_one(8'h01, 1'b0, 1'b0, 0, n, mx);
                push_one(pg,    1'b0, 1'b1, 0, n, mx);
                g = 0;
                have = 1'b1;
                last_pg = pg;
            end
            push_one(8'hE8,          1'b1, 1'b0, g, n, mx);
            push_one(rom[i][15:8],   1'b0, 1'b0, 0, n, mx);
            push_one(rom[i][7:0],    1'b0, 1'b1, 0, n, mx);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int mx);
        for (int i = 0; i < mx; i++) begin
            @(posedge clk); #1;
            if (done || err) break;
        end
        chk({nm, "_finished"}, 32'(done || err), 32'd1);
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {busy, done, err, rom_addr, valid, data, st, sp}, 32'd0);
    endtask

    initial begin
        int t0, b0;
        logic [10:0] snap;
        clk = 1'b0; arstn = 1'b0; start = 1'b0; ready = 1'b1;
        rom[0] = 24'h00_0B_24;
        rom[1] = 24'h00_0C_01;
        rom[2] = 24'h05_10_AA;
        rom[3] = 24'h05_11_BB;

        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        @(posedge clk); #1 arstn = 1'b1;

        // Full load, with a start pulse while busy
        t0 = n_txn;
        push_load(1000);
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rom_addr == 2'd2) break;
        end
        pulse_start();
        chk("busy_start_addr", 32'(rom_addr), 32'd2);
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_end("load1", 800);
        chk("load1_flags", {busy, done, err}, 32'b010);
        chk("load1_addr", 32'(rom_addr), 32'd3);
        chk("load1_sb_empty", 32'(sb.size()), 32'd0);
        chk("load1_txn_count", 32'(n_txn - t0), 32'(EXP_TXN));

        // NACK on the second byte of entry 1
        nack_at = bus_bytes + 8;
        push_load(8);
        pulse_start();
        wait_end("nack", 800);
        chk("nack_flags", {busy, done, err}, 32'b001);
        chk("nack_addr", 32'(rom_addr), 32'd1);
        chk("nack_sb_empty", 32'(sb.size()), 32'd0);
        b0 = n_bytes;
        repeat (20) @(posedge clk);
        #1;
        chk("nack_quiet", 32'(n_bytes - b0), 32'd0);
        chk("nack_valid_low", 32'(valid), 32'd0);
        chk("nack_err_held", 32'(err), 32'd1);
        nack_at = 0;

        // Byte master stalls for 5 cycles on the first byte
        @(posedge clk); #1 ready = 1'b0;
        push_load(1000);
        pulse_start();
        chk("restart_clears_err", {busy, err}, 32'b10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) break;
        end
        snap = {valid, data, st, sp};
        chk("stall_valid_seen", 32'(valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_hold_%0d", k), 32'({valid, data, st, sp}), 32'(snap));
        end
        @(posedge clk); #1 ready = 1'b1;
        wait_end("stall", 800);
        chk("stall_flags", {busy, done, err}, 32'b010);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the pause, then reload from entry 0
        push_load(6);
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("pre_pause_sb_empty", 32'(sb.size()), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("in_pause", {busy, valid, rom_addr}, 32'b1000);
        arstn = 1'b0;
        #1 check_zero("reset_in_pause");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        arstn = 1'b1;
        t0 = n_txn;
        push_load(1000);
        pulse_start();
        wait_end("reload", 800);
        chk("reload_flags", {busy, done, err}, 32'b010);
        chk("reload_sb_empty", 32'(sb.size()), 32'd0);
        chk("reload_txn_count", 32'(n_txn - t0), 32'(EXP_TXN));
        chk("flags_gated_by_valid", 32'(flag_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
